usart_tx_frame: RTL

Transmit half of the USART: serialises one character per frame onto the tx line from the transmit data register (UDR). It sits between the UDR/control-register logic and the pin, clocked by the clock generator's oversampled tx clock. It produces frames bit-compatible with the receive path: highest configured data bit first, optional even/odd parity, and one or two stop bits. It signals UDR consumption and transmit completion.

---
 rtl/usart_tx_frame.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/usart_tx_frame.sv
// rtl/usart_tx_frame.sv - USART transmit framer: start, 5..9 data bits MSB first, optional parity, 1 or 2 stops
module usart_tx_frame (
    input  logic       i_txclk,
    input  logic       i_rst,
    input  logic       i_txen,
    input  logic [2:0] i_ucsz,
    input  logic [1:0] i_upm,
    input  logic       i_usbs,
    input  logic       i_u2x,
    input  logic       i_umsel,
    input  logic [8:0] i_udr,
    input  logic       i_udr_valid,
    output logic       o_udr_read,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_complete
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t     state_q;
    logic [3:0] tick_q;
    logic [3:0] bitcnt_q;
    logic [8:0] shift_q;
    logic       par_q;
    logic       par_en_q;
    logic       usbs_q;
    logic       u2x_q;
    logic       umsel_q;
    logic       tx_q;
    logic       complete_q;

    logic       ucsz_ok;
    logic       load_req;
    logic [3:0] bl_last;
    logic       bit_end;
    logic       last_stop;
    logic [3:0] n_d;
    logic [8:0] shift_d;
    logic       data_xor;
    logic       par_d;

    assign ucsz_ok   = ~i_ucsz[2] | (i_ucsz == 3'b111);
    assign load_req  = i_txen & i_udr_valid & ucsz_ok;
    assign bl_last   = umsel_q ? 4'd0 : (u2x_q ? 4'd7 : 4'd15);
    assign bit_end   = (tick_q == bl_last);
    assign last_stop = (state_q == STOP2) | ((state_q == STOP1) & ~usbs_q);

    assign o_udr_read    = load_req & ((state_q == IDLE) | (last_stop & bit_end));
    assign o_tx          = tx_q;
    assign o_tx_busy     = (state_q != IDLE);
    assign o_tx_complete = complete_q;

    // Data is left-aligned at load so the frame always shifts out of bit 8.
    always_comb begin
        n_d      = 4'd9;
        shift_d  = i_udr;
        data_xor = ^i_udr;
        case (i_ucsz)
            3'b000: begin
                n_d      = 4'd5;
                shift_d  = {i_udr[4:0], 4'b0000};
                data_xor = ^i_udr[4:0];
            end
            3'b001: begin
                n_d      = 4'd6;
                shift_d  = {i_udr[5:0], 3'b000};
                data_xor = ^i_udr[5:0];
            end
            3'b010: begin
                n_d      = 4'd7;
                shift_d  = {i_udr[6:0], 2'b00};
                data_xor = ^i_udr[6:0];
            end
            3'b011: begin
                n_d      = 4'd8;
                shift_d  = {i_udr[7:0], 1'b0};
                data_xor = ^i_udr[7:0];
            end
            default: begin
                n_d      = 4'd9;
                shift_d  = i_udr;
                data_xor = ^i_udr;
            end
        endcase
        par_d = data_xor ^ i_upm[0];
    end

    always_ff @(posedge i_txclk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            tick_q     <= 4'd0;
            bitcnt_q   <= 4'd0;
            shift_q    <= 9'd0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            usbs_q     <= 1'b0;
            u2x_q      <= 1'b0;
            umsel_q    <= 1'b0;
            tx_q       <= 1'b1;
            complete_q <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            if (o_udr_read) begin
                state_q  <= START;
                tick_q   <= 4'd0;
                bitcnt_q <= n_d;
                shift_q  <= shift_d;
                par_q    <= par_d;
                par_en_q <= i_upm[1];
                usbs_q   <= i_usbs;
                u2x_q    <= i_u2x;
                umsel_q  <= i_umsel;
                tx_q     <= 1'b0;
            end else if (state_q != IDLE) begin
                tick_q <= bit_end ? 4'd0 : tick_q + 4'd1;
                if (bit_end) begin
                    case (state_q)
                        START: begin
                            state_q  <= DATA;
                            tx_q     <= shift_q[8];
                            shift_q  <= {shift_q[7:0], 1'b0};
                            bitcnt_q <= bitcnt_q - 4'd1;
                        end
                        DATA: begin
                            if (bitcnt_q == 4'd0) begin
                                state_q <= par_en_q ? PARITY : STOP1;
                                tx_q    <= par_en_q ? par_q : 1'b1;
                            end else begin
                                tx_q     <= shift_q[8];
                                shift_q  <= {shift_q[7:0], 1'b0};
                                bitcnt_q <= bitcnt_q - 4'd1;
                            end
                        end
                        PARITY: begin
                            state_q <= STOP1;
                            tx_q    <= 1'b1;
                        end
                        STOP1: begin
                            tx_q <= 1'b1;
                            if (usbs_q) begin
                                state_q <= STOP2;
                            end else begin
                                state_q    <= IDLE;
                                complete_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q    <= IDLE;
                            tx_q       <= 1'b1;
                            complete_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule
